// File: rtl/max_frame_seq.sv
// Streams one frame of unsigned samples and reports the maximum and index of its first occurrence.
// Optional build macro MAXSEQ_MIN_EN adds a res_min output carrying the frame minimum.
module max_frame_seq #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic [CNT_W-1:0]  res_idx,
   input  logic              res_ready,
   output logic              busy
`ifdef MAXSEQ_MIN_EN
   ,
   output logic [DATA_W-1:0] res_min
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
`ifdef MAXSEQ_MIN_EN
   logic [DATA_W-1:0] min_q, min_d;
`endif

   logic             beat;
   logic             first_beat;
   logic             last_beat;
   logic [CNT_W-1:0] len_m1;

   assign beat       = (state_q == S_RUN) && in_valid;
   assign first_beat = (cnt_q == '0);
   assign len_m1     = len_q - CNT_W'(1);
   // len_q is never 0 in RUN, so the final beat lands at most at 2^CNT_W-2 and cnt never wraps.
   assign last_beat  = (cnt_q == len_m1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      idx_d   = idx_q;
`ifdef MAXSEQ_MIN_EN
      min_d   = min_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && (len != '0)) begin
               len_d   = len;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (beat) begin
               cnt_d = cnt_q + CNT_W'(1);
               // First beat seeds the trackers; later beats replace only on a strict win.
               if (first_beat) begin
                  max_d = in_data;
                  idx_d = '0;
               end else if (max_q < in_data) begin
                  max_d = in_data;
                  idx_d = cnt_q;
               end
`ifdef MAXSEQ_MIN_EN
               if (first_beat || (in_data < min_q)) begin
                  min_d = in_data;
               end
`endif
               if (last_beat) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         max_q   <= '0;
         idx_q   <= '0;
`ifdef MAXSEQ_MIN_EN
         min_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
`ifdef MAXSEQ_MIN_EN
         min_q   <= min_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_RUN);
   assign res_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign res_data  = max_q;
   assign res_idx   = idx_q;
`ifdef MAXSEQ_MIN_EN
   assign res_min   = min_q;
`endif

endmodule

// File: tb/tb_max_frame_seq.sv
// Directed bench for max_frame_seq: a queue-based frame model checked every cycle plus literal checks.
module tb_max_frame_seq;
   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, res_ready;
   logic [CW-1:0] len;
   logic [DW-1:0] in_data;
   logic          in_ready, res_valid, busy;
   logic [DW-1:0] res_data;
   logic [CW-1:0] res_idx;
`ifdef MAXSEQ_MIN_EN
   logic [DW-1:0] res_min;
`endif

   max_frame_seq #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
      .res_ready(res_ready), .busy(busy)
`ifdef MAXSEQ_MIN_EN
      , .res_min(res_min)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame model: phase 0 idle, 1 collecting, 2 result pending.
   int            m_phase = 0;
   int            m_len   = 0;
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_max = '0;
   logic [DW-1:0] m_min = '0;
   int            m_idx = 0;
   bit            m_zero = 1'b1;
   bit            chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_q.delete(); m_max = '0; m_min = '0; m_idx = 0;
         m_zero = 1'b1; chk_en = 1'b1;
      end else begin
         case (m_phase)
            0: if (start && len != 0) begin
                  m_len = len; m_q.delete(); m_phase = 1; m_zero = 1'b0;
               end
            1: if (in_valid) begin
                  m_q.push_back(in_data);
                  if (m_q.size() == m_len) begin
                     m_max = m_q[0]; m_min = m_q[0]; m_idx = 0;
                     foreach (m_q[i]) begin
                        if (m_q[i] > m_max) begin m_max = m_q[i]; m_idx = i; end
                        if (m_q[i] < m_min) m_min = m_q[i];
                     end
                     m_phase = 2;
                  end
               end
            default: if (res_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, m_phase == 1);
         chk("res_valid", res_valid, m_phase == 2);
         chk("busy", busy, m_phase != 0);
         if (m_phase == 2 || m_zero) begin
            chk("res_data", res_data, m_max);
            chk("res_idx", res_idx, m_idx);
`ifdef MAXSEQ_MIN_EN
            chk("res_min", res_min, m_min);
`endif
         end
      end
   end

   task automatic cyc(input bit st, input int ln, input bit iv, input int d, input bit rr);
      start = st; len = ln[CW-1:0]; in_valid = iv; in_data = d[DW-1:0]; res_ready = rr;
      @(posedge clk); #1;
   endtask

   bit iv_pat[5] = '{1, 0, 0, 1, 1};
   int d_pat[5]  = '{3, 9, 7, 2, 5};

   initial begin
      rst = 1'b1; start = 0; len = '0; in_valid = 0; in_data = '0; res_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready", in_ready, 0); chk("rst res_valid", res_valid, 0);
      chk("rst res_data", res_data, 0); chk("rst res_idx", res_idx, 0);
      chk("rst busy", busy, 0);
      rst = 1'b0;

      // Repeated maximum keeps its first index.
      cyc(1, 4, 0, 0, 0);
      cyc(0, 0, 1, 'h10, 0); cyc(0, 0, 1, 'h80, 0); cyc(0, 0, 1, 'h80, 0);
      chk("A early", res_valid, 0);
      cyc(0, 0, 1, 'h05, 0);
      chk("A res_valid", res_valid, 1); chk("A res_data", res_data, 'h80); chk("A res_idx", res_idx, 1);
`ifdef MAXSEQ_MIN_EN
      chk("A res_min", res_min, 'h05);
`endif
      // Hold the result under back-pressure while start is ignored.
      for (int i = 0; i < 5; i++) begin
         cyc(1, 4, 0, 0, 0);
         chk("hold valid", res_valid, 1); chk("hold data", res_data, 'h80);
         chk("hold idx", res_idx, 1); chk("hold in_ready", in_ready, 0);
      end
      cyc(0, 0, 0, 0, 1);
      chk("B busy", busy, 0); chk("B res_valid", res_valid, 0);

      // Bubbles do not count as beats.
      cyc(1, 3, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, iv_pat[i], d_pat[i], 0);
         if (i == 3) chk("C not done", res_valid, 0);
      end
      chk("C done", res_valid, 1); chk("C res_data", res_data, 5); chk("C res_idx", res_idx, 2);
      cyc(0, 0, 0, 0, 1);

      // Zero-length request is ignored.
      cyc(1, 0, 0, 0, 0);
      chk("D busy", busy, 0); chk("D in_ready", in_ready, 0);
      cyc(0, 0, 0, 0, 0);
      chk("D busy2", busy, 0);

      // Longest frame, ascending samples.
      cyc(1, 15, 0, 0, 0);
      for (int i = 0; i < 15; i++) cyc(0, 0, 1, i, 0);
      chk("E res_valid", res_valid, 1); chk("E res_data", res_data, 14); chk("E res_idx", res_idx, 14);
      cyc(0, 0, 0, 0, 1);

      // Equal leading samples, max on the first beat.
      cyc(1, 3, 0, 0, 0);
      cyc(0, 0, 1, 'h50, 0); cyc(0, 0, 1, 'h50, 0); cyc(0, 0, 1, 'h20, 0);
      chk("F res_data", res_data, 'h50); chk("F res_idx", res_idx, 0);
`ifdef MAXSEQ_MIN_EN
      chk("F res_min", res_min, 'h20);
`endif
      cyc(0, 0, 0, 0, 1);

      // Reset while a result is pending drops it.
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 'h33, 0);
      chk("G res_valid", res_valid, 1);
      rst = 1'b1; cyc(0, 0, 0, 0, 0); rst = 1'b0;
      chk("G after rst valid", res_valid, 0); chk("G after rst data", res_data, 0);

      // Reset mid-frame wins over start and handshakes in the same cycle.
      cyc(1, 5, 0, 0, 0);
      cyc(0, 0, 1, 'h44, 0); cyc(0, 0, 1, 'h66, 0);
      rst = 1'b1; cyc(1, 5, 1, 'h77, 1); rst = 1'b0;
      chk("H busy", busy, 0); chk("H in_ready", in_ready, 0); chk("H res_valid", res_valid, 0);
      chk("H res_data", res_data, 0); chk("H res_idx", res_idx, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 'h00, 0);
      chk("H2 res_valid", res_valid, 1); chk("H2 res_data", res_data, 0); chk("H2 res_idx", res_idx, 0);
      cyc(0, 0, 0, 0, 1);

      // A few frames with irregular valid and ready, checked by the model.
      for (int f = 0; f < 3; f++) begin
         int n;
         n = $urandom_range(15, 1);
         cyc(1, n, 0, 0, 0);
         begin
            int k;
            k = 0;
            while (busy && k < 200) begin
               cyc(0, 0, $urandom_range(1, 0), $urandom_range(255, 0), $urandom_range(1, 0));
               k++;
            end
            chk("R frame end", busy, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/max_frame_seq.md
MAX_FRAME_SEQ -- requirements
Module: max_frame_seq

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the sample width.
REQ-002 Parameter CNT_W, default 4, SHALL set the frame-length and index width (frames of 1 to 2^CNT_W-1 samples).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  input  1  SHALL request a new frame (sampled only in IDLE).
REQ-006 len  input  CNT_W  SHALL give the frame sample count, captured with start.
REQ-007 in_valid  input  1  SHALL qualify in_data.
REQ-008 in_data  input  DATA_W  SHALL carry the sample (unsigned).
REQ-009 in_ready  output  1  SHALL signal that a sample can be accepted.
REQ-010 res_valid  output  1  SHALL qualify the result.
REQ-011 res_data  output  DATA_W  SHALL carry the frame maximum.
REQ-012 res_idx  output  CNT_W  SHALL carry the index of the first maximum sample (0-based).
REQ-013 res_ready  input  1  SHALL accept the result.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: start=1 with len!=0 SHALL capture len, clear the sample counter, and move to RUN next cycle; start=1 with len=0 SHALL be ignored (stays IDLE).
REQ-017 RUN: in_ready SHALL be 1; a beat transfers when in_valid and in_ready are both 1.
REQ-018 First beat of a frame SHALL load max<=in_data and idx<=0 unconditionally.
REQ-019 Later beats SHALL replace max/idx only when max < in_data (strict, unsigned); equal values SHALL keep the earlier index.
REQ-020 The counter SHALL increment per beat; the beat with count==len-1 SHALL move the FSM to DONE on that edge.
REQ-021 The result SHALL appear with res_valid=1 the cycle after the last beat (1-cycle latency).
REQ-022 DONE: res_valid SHALL be 1 and in_ready 0; res_data/res_idx SHALL hold stable until res_valid && res_ready, then the FSM SHALL return to IDLE.
REQ-023 start SHALL be ignored in RUN and DONE; a new frame may be started in the first IDLE cycle after the handshake.
REQ-024 in_ready SHALL be 0 in IDLE and DONE; in_valid bubbles in RUN SHALL not advance the counter.
REQ-025 The counter SHALL never wrap: len=2^CNT_W-1 SHALL complete at count=2^CNT_W-2.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and zero the counter, max, idx, and captured len.
REQ-027 Reset outputs: in_ready=0, res_valid=0, res_data=0, res_idx=0, busy=0.
REQ-028 rst asserted mid-frame (RUN or DONE) SHALL abandon the frame with no result emitted.
REQ-029 rst SHALL take priority over start and all handshakes in the same cycle.

Configuration
REQ-030 Macro MAXSEQ_MIN_EN, when defined, SHALL add output res_min (DATA_W) carrying the frame minimum, tracked in parallel with the same first-beat load, strict replacement (in_data < min), and DONE-hold rules, and reset to 0.
REQ-031 Without MAXSEQ_MIN_EN the res_min port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then start, len=4, samples 0x10,0x80,0x80,0x05 -> res_valid one cycle after the 4th beat, res_data=0x80, res_idx=1 (res_min=0x05 with MAXSEQ_MIN_EN).
REQ-033 len=3, in_valid toggled 1,0,0,1,1 -> exactly 3 beats accepted, DONE reached only after the 3rd beat.
REQ-034 In DONE, hold res_ready=0 for 5 cycles while driving start=1 -> outputs stable, no restart; res_ready=1 -> IDLE next cycle, busy=0.
REQ-035 start with len=0 -> busy stays 0, in_ready stays 0; then len=15 with samples 0..14 -> res_data=14, res_idx=14.
REQ-036 rst=1 after 2 beats of a len=5 frame -> next cycle IDLE, all outputs 0; new frame len=1, sample 0x00 -> res_data=0x00, res_idx=0.
